// File: rtl/ltc2308_scan_sequencer.sv
// ---------------------------------------------------------------------------
// ltc2308_scan_sequencer
//
// Purpose:
//   Drives the LTC2308 8-channel 12-bit SAR ADC serial pins and round-robins
//   conversions over a channel mask. The LTC2308 is pipelined by one frame:
//   the config word shifted in during frame N selects the conversion that is
//   read out during frame N+1. Each result is tagged with its channel and
//   presented as a single-cycle pulse.
//
// Ports:
//   clock          in   system clock
//   reset          in   synchronous, active-high reset
//   enable         in   1 = keep scanning, 0 = stop after the current frame
//   channel_mask   in   bit i enables single-ended channel i
//   unipolar       in   UNI bit of the config word
//   CONVST         out  ADC conversion start
//   SCK            out  ADC serial clock, idles low
//   SDI            out  ADC config data in
//   SDO            in   ADC data out, MSB first
//   busy           out  1 whenever the sequencer is not idle
//   result_valid   out  1-cycle pulse, result_* valid
//   result_channel out  channel that result_data belongs to
//   result_data    out  12-bit conversion code
//   scan_done      out  pulses with result_valid on the last channel of a pass
// ---------------------------------------------------------------------------
module ltc2308_scan_sequencer #(
  parameter int CLK_DIV       = 2,
  parameter int CONVST_CYCLES = 3,
  parameter int CONV_CYCLES   = 80
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  channel_mask,
  input  logic        unipolar,
  output logic        CONVST,
  output logic        SCK,
  output logic        SDI,
  input  logic        SDO,
  output logic        busy,
  output logic        result_valid,
  output logic [2:0]  result_channel,
  output logic [11:0] result_data,
  output logic        scan_done
);

  localparam int CNT_MAX = (CONV_CYCLES > CONVST_CYCLES) ?
                           ((CONV_CYCLES > CLK_DIV) ? CONV_CYCLES : CLK_DIV) :
                           ((CONVST_CYCLES > CLK_DIV) ? CONVST_CYCLES : CLK_DIV);
  localparam int CW = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    CONV_HI,
    CONV_WAIT,
    SHIFT,
    FINISH
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      fall_q, fall_d;
  logic            sck_q, sck_d;
  logic [11:0]     shreg_q, shreg_d;
  logic [2:0]      cur_ch_q, cur_ch_d;
  logic [2:0]      nxt_ch_q, nxt_ch_d;
  logic            uni_q, uni_d;
  logic            primed_q, primed_d;
  logic            res_valid_q, res_valid_d;
  logic [2:0]      res_ch_q, res_ch_d;
  logic [11:0]     res_data_q, res_data_d;
  logic            done_q, done_d;

  logic [5:0]      cfg;
  logic [5:0]      cfg_shifted;
  logic            start_ok;

  // Lowest set mask bit strictly above cur when after_cur is set, wrapping to
  // the lowest set bit; with after_cur clear it simply returns the lowest bit.
  function automatic logic [2:0] pick_channel(input logic [7:0] mask,
                                              input logic [2:0] cur,
                                              input logic       after_cur);
    logic [2:0] lowest;
    logic [2:0] above;
    logic       found;
    lowest = '0;
    above  = '0;
    found  = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) begin
        lowest = 3'(i);
        if (3'(i) > cur) begin
          above = 3'(i);
          found = 1'b1;
        end
      end
    end
    return (after_cur && found) ? above : lowest;
  endfunction

  // Config word bits in shift order: S/D, O/S, S1, S0, UNI, SLP.
  assign cfg         = {1'b1, nxt_ch_q[0], nxt_ch_q[2], nxt_ch_q[1], uni_q, 1'b0};
  assign cfg_shifted = cfg << fall_q;
  assign start_ok    = enable && (channel_mask != 8'h00);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fall_q      <= '0;
      sck_q       <= 1'b0;
      shreg_q     <= '0;
      cur_ch_q    <= '0;
      nxt_ch_q    <= '0;
      uni_q       <= 1'b0;
      primed_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fall_q      <= fall_d;
      sck_q       <= sck_d;
      shreg_q     <= shreg_d;
      cur_ch_q    <= cur_ch_d;
      nxt_ch_q    <= nxt_ch_d;
      uni_q       <= uni_d;
      primed_q    <= primed_d;
      res_valid_q <= res_valid_d;
      res_ch_q    <= res_ch_d;
      res_data_q  <= res_data_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fall_d      = fall_q;
    sck_d       = sck_q;
    shreg_d     = shreg_q;
    cur_ch_d    = cur_ch_q;
    nxt_ch_d    = nxt_ch_q;
    uni_d       = uni_q;
    primed_d    = primed_q;
    res_valid_d = 1'b0;
    res_ch_d    = res_ch_q;
    res_data_d  = res_data_q;
    done_d      = 1'b0;
    CONVST      = 1'b0;
    SDI         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d  = CONV_HI;
          cnt_d    = '0;
          nxt_ch_d = pick_channel(channel_mask, cur_ch_q, 1'b0);
          uni_d    = unipolar;
        end
      end

      CONV_HI: begin
        CONVST = 1'b1;
        if (cnt_q == CW'(CONVST_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = CONV_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      CONV_WAIT: begin
        SDI = cfg[5];
        if (cnt_q == CW'(CONV_CYCLES - 1)) begin
          cnt_d   = '0;
          fall_d  = '0;
          sck_d   = 1'b0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // The result registers are loaded on the last falling SCK edge so they
      // are already valid during the single FINISH cycle.
      SHIFT: begin
        SDI = cfg_shifted[5];
        if (cnt_q == CW'(CLK_DIV - 1)) begin
          cnt_d = '0;
          sck_d = ~sck_q;
          if (!sck_q) begin
            shreg_d = {shreg_q[10:0], SDO};
          end else begin
            fall_d = fall_q + 4'd1;
            if (fall_q == 4'd11) begin
              state_d     = FINISH;
              res_valid_d = primed_q;
              if (primed_q) begin
                res_ch_d   = cur_ch_q;
                res_data_d = shreg_q;
                done_d     = (nxt_ch_q <= cur_ch_q);
              end
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      FINISH: begin
        cur_ch_d = nxt_ch_q;
        primed_d = 1'b1;
        if (start_ok) begin
          state_d  = CONV_HI;
          cnt_d    = '0;
          nxt_ch_d = pick_channel(channel_mask, nxt_ch_q, 1'b1);
          uni_d    = unipolar;
        end else begin
          state_d  = IDLE;
          primed_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign SCK            = sck_q;
  assign busy           = (state_q != IDLE);
  assign result_valid   = res_valid_q;
  assign result_channel = res_ch_q;
  assign result_data    = res_data_q;
  assign scan_done      = done_q;

endmodule

// File: tb/tb_ltc2308_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ltc2308_scan_sequencer
//
// Bench for ltc2308_scan_sequencer at default parameters. A small LTC2308
// model captures the 6-bit config word on SCK rising edges and, at the next
// CONVST rise, starts serving the code of the channel that word selected
// (MSB first, advancing on SCK falling edges). A negedge monitor logs pin
// timing and result pulses into queues that each scenario task inspects.
// ---------------------------------------------------------------------------
module tb_ltc2308_scan_sequencer;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [7:0]  channelMask;
  logic        unipolar;
  logic        CONVST;
  logic        SCK;
  logic        SDI;
  logic        SDO;
  logic        busy;
  logic        resultValid;
  logic [2:0]  resultChannel;
  logic [11:0] resultData;
  logic        scanDone;

  int tests = 0;
  int fails = 0;

  ltc2308_scan_sequencer dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .channel_mask   (channelMask),
    .unipolar       (unipolar),
    .CONVST         (CONVST),
    .SCK            (SCK),
    .SDI            (SDI),
    .SDO            (SDO),
    .busy           (busy),
    .result_valid   (resultValid),
    .result_channel (resultChannel),
    .result_data    (resultData),
    .scan_done      (scanDone)
  );

  // 100 MHz system clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard stop in case a scenario wedges beyond its own bounded waits.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // ADC model: per-channel codes and one-frame pipeline.
  logic [11:0] codes [8];
  logic [5:0]  cfgShift    = '0;
  logic [5:0]  lastCfgWord = '0;
  logic [2:0]  lastCfgCh   = '0;
  logic [11:0] outWord     = '0;
  int          cfgBits     = 0;
  int          outIdx      = 12;
  logic        mConv       = 1'b0;
  logic        mSck        = 1'b0;

  always @(CONVST or SCK) begin
    if (CONVST && !mConv) begin
      outWord = codes[lastCfgCh];
      outIdx  = 0;
      cfgBits = 0;
    end
    if (SCK && !mSck && cfgBits < 6) begin
      cfgShift = {cfgShift[4:0], SDI};
      cfgBits++;
      if (cfgBits == 6) begin
        lastCfgWord = cfgShift;
        lastCfgCh   = {cfgShift[3], cfgShift[2], cfgShift[4]};
      end
    end
    if (!SCK && mSck) outIdx++;
    mConv = CONVST;
    mSck  = SCK;
  end

  assign SDO = (outIdx < 12) ? outWord[11 - outIdx] : 1'b0;

  // Monitor: sampled on the falling clock edge, away from DUT updates.
  int         cycleCount = 0;
  int         riseCyc[$];
  int         framePulses[$];
  int         convHiRuns[$];
  int         sckHighRuns[$];
  int         sckLowRuns[$];
  logic [2:0] resCh[$];
  logic [11:0] resData[$];
  logic       resDone[$];
  int         resFrame[$];
  int         busyCount   = 0;
  int         convHi      = 0;
  int         sckRun      = 0;
  int         sckRises    = 0;
  bit         lowFromFall = 1'b0;
  logic       prevConvst  = 1'b0;
  logic       prevSck     = 1'b0;

  always @(posedge clock) cycleCount++;

  always @(negedge clock) begin
    if (CONVST && !prevConvst) begin
      riseCyc.push_back(cycleCount);
      framePulses.push_back(sckRises);
      sckRises = 0;
    end
    if (CONVST) convHi++;
    else if (prevConvst) begin
      convHiRuns.push_back(convHi);
      convHi = 0;
    end
    if (SCK) begin
      if (!prevSck) begin
        if (lowFromFall) sckLowRuns.push_back(sckRun);
        sckRises++;
        sckRun = 0;
      end
      sckRun++;
    end else begin
      if (prevSck) begin
        sckHighRuns.push_back(sckRun);
        sckRun      = 0;
        lowFromFall = 1'b1;
      end else if (CONVST) begin
        lowFromFall = 1'b0;
      end
      sckRun++;
    end
    if (busy) busyCount++;
    if (resultValid) begin
      resCh.push_back(resultChannel);
      resData.push_back(resultData);
      resDone.push_back(scanDone);
      resFrame.push_back(riseCyc.size());
    end
    prevConvst = CONVST;
    prevSck    = SCK;
  end

  // Bounded wait until the result log holds at least target entries.
  task automatic waitResults(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clock);
      ok = (resCh.size() >= target);
    end
  endtask

  // Drop enable and wait (bounded) for the sequencer to go idle.
  task automatic waitIdle(output bit ok);
    enable = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clock);
      ok = (busy === 1'b0);
    end
  endtask

  task automatic test_reset();
    enable      = 1'b1;
    channelMask = 8'hFF;
    unipolar    = 1'b0;
    reset       = 1'b1;
    repeat (4) @(negedge clock);
    tests++;
    if ({CONVST, SCK, SDI, busy} !== 4'b0000) begin
      fails++;
      $display("[TB] FAIL reset_pins: got {CONVST,SCK,SDI,busy}=%b expected 0000",
               {CONVST, SCK, SDI, busy});
    end
    tests++;
    if ({resultValid, scanDone, resultChannel, resultData} !== 17'h0) begin
      fails++;
      $display("[TB] FAIL reset_results: got valid=%b done=%b ch=%0d data=%h expected all 0",
               resultValid, scanDone, resultChannel, resultData);
    end
    enable = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_single_channel();
    int bRes, bRise;
    bit ok;
    channelMask = 8'h08;
    unipolar    = 1'b1;
    bRes  = resCh.size();
    bRise = riseCyc.size();
    enable = 1'b1;
    waitResults(bRes + 1, 400, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL single_timeout: got no result, expected one within 400 cycles");
    end else begin
      tests++;
      if (resFrame[bRes] - bRise !== 2) begin
        fails++;
        $display("[TB] FAIL single_first_frame: result in frame %0d, expected frame 2",
                 resFrame[bRes] - bRise);
      end
      tests++;
      if (resCh[bRes] !== 3'd3 || resData[bRes] !== 12'hABC || resDone[bRes] !== 1'b1) begin
        fails++;
        $display("[TB] FAIL single_result: got ch=%0d data=%h done=%b expected ch=3 data=abc done=1",
                 resCh[bRes], resData[bRes], resDone[bRes]);
      end
      tests++;
      if (lastCfgWord !== 6'b110110) begin
        fails++;
        $display("[TB] FAIL single_cfg: got SDI word %b expected 110110", lastCfgWord);
      end
    end
    waitIdle(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL single_idle: busy still %b expected 0", busy);
    end
  endtask

  task automatic test_round_robin();
    int bRes;
    bit ok;
    logic [2:0] expCh [3];
    logic       expDone [3];
    expCh   = '{3'd0, 3'd2, 3'd0};
    expDone = '{1'b0, 1'b1, 1'b0};
    channelMask = 8'h05;
    unipolar    = 1'b0;
    bRes = resCh.size();
    enable = 1'b1;
    waitResults(bRes + 3, 700, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL rr_timeout: got %0d results expected 3", resCh.size() - bRes);
    end else begin
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (resCh[bRes+k] !== expCh[k] || resData[bRes+k] !== codes[expCh[k]] ||
            resDone[bRes+k] !== expDone[k]) begin
          fails++;
          $display("[TB] FAIL rr_result%0d: got ch=%0d data=%h done=%b expected ch=%0d data=%h done=%b",
                   k, resCh[bRes+k], resData[bRes+k], resDone[bRes+k],
                   expCh[k], codes[expCh[k]], expDone[k]);
        end
      end
    end
    waitIdle(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL rr_idle: busy still %b expected 0", busy);
    end
  endtask

  task automatic test_timing();
    int bRise, bHigh, bLow, bConv, badH, badL;
    bit ok;
    channelMask = 8'h01;
    unipolar    = 1'b0;
    bRise = riseCyc.size();
    bHigh = sckHighRuns.size();
    bLow  = sckLowRuns.size();
    bConv = convHiRuns.size();
    enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clock);
      ok = (riseCyc.size() >= bRise + 3);
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL timing_timeout: got %0d CONVST rises expected 3", riseCyc.size() - bRise);
    end else begin
      tests++;
      if (convHiRuns[bConv] !== 3 || convHiRuns[bConv+1] !== 3) begin
        fails++;
        $display("[TB] FAIL timing_convst_width: got %0d,%0d clocks expected 3,3",
                 convHiRuns[bConv], convHiRuns[bConv+1]);
      end
      tests++;
      if (riseCyc[bRise+1] - riseCyc[bRise] !== 132 || riseCyc[bRise+2] - riseCyc[bRise+1] !== 132) begin
        fails++;
        $display("[TB] FAIL timing_period: got %0d,%0d clocks expected 132,132",
                 riseCyc[bRise+1] - riseCyc[bRise], riseCyc[bRise+2] - riseCyc[bRise+1]);
      end
      tests++;
      if (framePulses[bRise+1] !== 12 || framePulses[bRise+2] !== 12) begin
        fails++;
        $display("[TB] FAIL timing_sck_count: got %0d,%0d pulses expected 12,12",
                 framePulses[bRise+1], framePulses[bRise+2]);
      end
      badH = 0;
      badL = 0;
      for (int i = bHigh; i < sckHighRuns.size(); i++) if (sckHighRuns[i] != 2) badH++;
      for (int i = bLow; i < sckLowRuns.size(); i++) if (sckLowRuns[i] != 2) badL++;
      tests++;
      if (badH !== 0 || sckHighRuns.size() - bHigh !== 24) begin
        fails++;
        $display("[TB] FAIL timing_sck_high: got %0d runs (%0d not 2 clocks) expected 24 runs of 2",
                 sckHighRuns.size() - bHigh, badH);
      end
      tests++;
      if (badL !== 0 || sckLowRuns.size() - bLow !== 22) begin
        fails++;
        $display("[TB] FAIL timing_sck_low: got %0d runs (%0d not 2 clocks) expected 22 runs of 2",
                 sckLowRuns.size() - bLow, badL);
      end
    end
    waitIdle(ok);
    tests++;
    if (!ok || SCK !== 1'b0) begin
      fails++;
      $display("[TB] FAIL timing_idle: got busy=%b SCK=%b expected 0,0", busy, SCK);
    end
  endtask

  task automatic test_enable_drop();
    int bRes, bRise;
    bit ok;
    channelMask = 8'h02;
    unipolar    = 1'b1;
    bRes = resCh.size();
    enable = 1'b1;
    waitResults(bRes + 1, 400, ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clock);
      ok = (SCK === 1'b1);
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL drop_reach_shift: got no SCK pulse expected one within 200 cycles");
    end else begin
      bRes  = resCh.size();
      bRise = riseCyc.size();
      enable = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
        @(negedge clock);
        ok = (resultValid === 1'b1);
      end
      tests++;
      if (!ok) begin
        fails++;
        $display("[TB] FAIL drop_result: got no result_valid expected one after enable drop");
      end else begin
        @(negedge clock);
        tests++;
        if (busy !== 1'b0) begin
          fails++;
          $display("[TB] FAIL drop_busy: got busy=%b expected 0 cycle after result", busy);
        end
      end
      repeat (300) @(negedge clock);
      tests++;
      if (resCh.size() - bRes !== 1 || riseCyc.size() - bRise !== 0) begin
        fails++;
        $display("[TB] FAIL drop_quiet: got %0d results %0d CONVST rises expected 1,0",
                 resCh.size() - bRes, riseCyc.size() - bRise);
      end else begin
        tests++;
        if (resCh[bRes] !== 3'd1 || resData[bRes] !== codes[1]) begin
          fails++;
          $display("[TB] FAIL drop_data: got ch=%0d data=%h expected ch=1 data=%h",
                   resCh[bRes], resData[bRes], codes[1]);
        end
      end
      tests++;
      if (SCK !== 1'b0 || CONVST !== 1'b0) begin
        fails++;
        $display("[TB] FAIL drop_pins: got SCK=%b CONVST=%b expected 0,0", SCK, CONVST);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int bConv, bRes, bRise;
    bit ok;
    channelMask = 8'h04;
    unipolar    = 1'b0;
    bConv = convHiRuns.size();
    enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clock);
      ok = (convHiRuns.size() > bConv);
    end
    repeat (10) @(negedge clock);
    tests++;
    if (!ok || SDI !== 1'b1) begin
      fails++;
      $display("[TB] FAIL midreset_wait_sdi: got reached=%b SDI=%b expected 1,1", ok, SDI);
    end
    bRes = resCh.size();
    reset = 1'b1;
    @(negedge clock);
    tests++;
    if ({CONVST, SCK, SDI, busy} !== 4'b0000) begin
      fails++;
      $display("[TB] FAIL midreset_pins: got {CONVST,SCK,SDI,busy}=%b expected 0000",
               {CONVST, SCK, SDI, busy});
    end
    @(negedge clock);
    reset = 1'b0;
    bRise = riseCyc.size();
    waitResults(bRes + 1, 400, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL midreset_timeout: got no result expected one within 400 cycles");
    end else begin
      tests++;
      if (resFrame[bRes] - bRise !== 2 || resCh[bRes] !== 3'd2 || resData[bRes] !== codes[2]) begin
        fails++;
        $display("[TB] FAIL midreset_result: got frame=%0d ch=%0d data=%h expected frame=2 ch=2 data=%h",
                 resFrame[bRes] - bRise, resCh[bRes], resData[bRes], codes[2]);
      end
    end
    waitIdle(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL midreset_idle: busy still %b expected 0", busy);
    end
  endtask

  task automatic test_empty_mask();
    int bRes, bRise, bBusy, bHigh;
    bit ok;
    channelMask = 8'h00;
    unipolar    = 1'b0;
    bRes  = resCh.size();
    bRise = riseCyc.size();
    bBusy = busyCount;
    bHigh = sckHighRuns.size();
    enable = 1'b1;
    repeat (300) @(negedge clock);
    tests++;
    if (busyCount - bBusy !== 0 || riseCyc.size() - bRise !== 0 ||
        sckHighRuns.size() - bHigh !== 0 || resCh.size() - bRes !== 0) begin
      fails++;
      $display("[TB] FAIL empty_idle: got busy=%0d convst=%0d sck=%0d results=%0d expected all 0",
               busyCount - bBusy, riseCyc.size() - bRise, sckHighRuns.size() - bHigh,
               resCh.size() - bRes);
    end
    channelMask = 8'h80;
    waitResults(bRes + 3, 700, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL ch7_timeout: got %0d results expected 3", resCh.size() - bRes);
    end else begin
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (resCh[bRes+k] !== 3'd7 || resData[bRes+k] !== 12'hF0F || resDone[bRes+k] !== 1'b1) begin
          fails++;
          $display("[TB] FAIL ch7_result%0d: got ch=%0d data=%h done=%b expected ch=7 data=f0f done=1",
                   k, resCh[bRes+k], resData[bRes+k], resDone[bRes+k]);
        end
      end
    end
    waitIdle(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL ch7_idle: busy still %b expected 0", busy);
    end
  endtask

  initial begin
    codes[0] = 12'h123;
    codes[1] = 12'h7E1;
    codes[2] = 12'h5A5;
    codes[3] = 12'hABC;
    codes[4] = 12'h444;
    codes[5] = 12'h555;
    codes[6] = 12'h666;
    codes[7] = 12'hF0F;
    reset       = 1'b1;
    enable      = 1'b0;
    channelMask = 8'h00;
    unipolar    = 1'b0;

    test_reset();
    test_single_channel();
    test_round_robin();
    test_timing();
    test_enable_drop();
    test_reset_midframe();
    test_empty_mask();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
